// File: rtl/memory_arbiter_if.sv
// Bundle of cache-side request/response and memory-side signals for memory_arbiter.
// slave is the arbiter's view; master is the view of the caches plus the memory model.
interface memory_arbiter_if #(
  parameter int DATAWIDTH = 32
);
  logic                 i_req;
  logic [DATAWIDTH-1:0] i_addr;
  logic [DATAWIDTH-1:0] i_rdata;
  logic                 i_done;
  logic                 d_req;
  logic                 d_write;
  logic [DATAWIDTH-1:0] d_addr;
  logic [DATAWIDTH-1:0] d_wdata;
  logic [DATAWIDTH-1:0] d_rdata;
  logic                 d_done;
  logic                 mem_visit;
  logic                 mem_write_enable;
  logic [DATAWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_data;
  logic [DATAWIDTH-1:0] mem_outp;
  logic                 mem_valid;
  logic                 err;
  logic                 busy;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_outp, mem_valid,
    output i_rdata, i_done, d_rdata, d_done, mem_visit, mem_write_enable,
           mem_addr, mem_data, err, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_outp, mem_valid,
    input  i_rdata, i_done, d_rdata, d_done, mem_visit, mem_write_enable,
           mem_addr, mem_data, err, busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache (read-only) and the D-cache.
// One transaction in flight; a silent memory is abandoned after TIMEOUT cycles with err.
module memory_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 15
) (
  input logic               clock,
  input logic               reset,
  memory_arbiter_if.slave   bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // state  | meaning
  // IDLE   | waiting for a request, arbitration happens here
  // ACCESS | memory strobed, waiting for mem_valid or timeout
  // RESP   | done (and err) pulse to the owner, then back to IDLE
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;     // 0 = I, 1 = D
  logic                 owner_q, owner_d;
  logic                 wr_q, wr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 visit_q, visit_d;
  logic                 we_q, we_d;
  logic [DATAWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [DATAWIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATAWIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 pick_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      visit_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      visit_q   <= visit_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // D wins only if I is idle or I was served last
  assign pick_d = bus.d_req && (!bus.i_req || !last_q);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    visit_d   = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_d = pick_d;
          wr_d    = pick_d ? bus.d_write : 1'b0;
          addr_d  = pick_d ? bus.d_addr : bus.i_addr;
          data_d  = pick_d ? bus.d_wdata : '0;
          cnt_d   = '0;
          visit_d = 1'b1;
          we_d    = pick_d ? bus.d_write : 1'b0;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (bus.mem_valid || cnt_q == CNT_LAST) begin
          if (owner_q) begin
            d_rdata_d = bus.mem_valid ? bus.mem_outp : '0;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = bus.mem_valid ? bus.mem_outp : '0;
            i_done_d  = 1'b1;
          end
          err_d   = !bus.mem_valid;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          visit_d = 1'b1;
          we_d    = wr_q;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_visit        = visit_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_data         = data_q;
  assign bus.i_rdata          = i_rdata_q;
  assign bus.d_rdata          = d_rdata_q;
  assign bus.i_done           = i_done_q;
  assign bus.d_done           = d_done_q;
  assign bus.err              = err_q;
  assign bus.busy             = busy_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus pushes expected completions and memory accesses,
// a memory responder and a completion monitor pop and compare independently.
module tb_memory_arbiter;
  logic clock;
  logic reset;
  memory_arbiter_if #(.DATAWIDTH(32)) bus ();

  memory_arbiter #(.DATAWIDTH(32), .TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    bit          chk_data;
    logic [31:0] data;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];
  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  logic [31:0] mem_rsp = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // memory model: answers on the mem_lat-th ACCESS cycle (0 = never), checks the strobed access
  initial begin
    int acc_cycle;
    acc_t a;
    acc_cycle = 0;
    bus.mem_valid = 1'b0;
    bus.mem_outp  = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_visit) begin
        acc_cycle++;
        if (acc_q.size() == 0) flag("unexpected_access");
        else begin
          a = acc_q[0];
          check("mem_addr", bus.mem_addr, a.addr);
          check("mem_write_enable", 32'(bus.mem_write_enable), 32'(a.we));
          if (a.chk_data) check("mem_data", bus.mem_data, a.data);
        end
        bus.mem_valid = (mem_lat != 0) && (acc_cycle == mem_lat);
        bus.mem_outp  = bus.mem_valid ? mem_rsp : 32'h0;
      end else begin
        if (acc_cycle > 0 && acc_q.size() > 0) void'(acc_q.pop_front());
        acc_cycle = 0;
        bus.mem_valid = 1'b0;
        bus.mem_outp  = '0;
      end
    end
  end

  // completion monitor
  initial begin
    logic [31:0] held_i, held_d;
    exp_t e;
    held_i = '0;
    held_d = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        held_i = '0;
        held_d = '0;
      end else begin
        if (bus.err && !(bus.i_done || bus.d_done)) flag("err_without_done");
        if (bus.i_done && bus.d_done) flag("both_done");
        else if (bus.i_done || bus.d_done) begin
          if (exp_q.size() == 0) flag("unexpected_done");
          else begin
            e = exp_q.pop_front();
            check("done_port", 32'(bus.d_done), 32'(e.port));
            check("err", 32'(bus.err), 32'(e.err));
            if (e.port) begin
              check("d_rdata", bus.d_rdata, e.rdata);
              check("i_rdata_hold", bus.i_rdata, held_i);
              held_d = e.rdata;
            end else begin
              check("i_rdata", bus.i_rdata, e.rdata);
              check("d_rdata_hold", bus.d_rdata, held_d);
              held_i = e.rdata;
            end
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_visit"}, 32'(bus.mem_visit), 0);
    check({tag, "_mem_we"}, 32'(bus.mem_write_enable), 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_data"}, bus.mem_data, 0);
    check({tag, "_i_rdata"}, bus.i_rdata, 0);
    check({tag, "_d_rdata"}, bus.d_rdata, 0);
    check({tag, "_i_done"}, 32'(bus.i_done), 0);
    check({tag, "_d_done"}, 32'(bus.d_done), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  // single transaction, called at a negedge while the DUT is IDLE
  task automatic run_txn(input bit port, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rsp,
                         input bit exp_err, input logic [31:0] exp_rdata, input int exp_edges);
    acc_t a;
    exp_t e;
    int n;
    bit done;
    mem_lat = lat;
    mem_rsp = rsp;
    a.addr = addr; a.we = wr; a.chk_data = wr; a.data = wdata;
    acc_q.push_back(a);
    e.port = port; e.rdata = exp_rdata; e.err = exp_err;
    exp_q.push_back(e);
    if (port) begin
      bus.d_req = 1'b1; bus.d_write = wr; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      done = port ? bus.d_done : bus.i_done;
    end
    check("done_latency", n, exp_edges);
    check("busy_in_resp", 32'(bus.busy), 1);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_write = 1'b0;
    @(negedge clock);
    check("busy_after", 32'(bus.busy), 0);
  endtask

  // both ports held; expects strictly alternating grants starting with I, 3 cycles apart
  task automatic run_contention(input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] rsp, input int rounds);
    acc_t a;
    exp_t e;
    int cyc, seen, prev;
    mem_lat = 1;
    mem_rsp = rsp;
    for (int k = 0; k < rounds; k++) begin
      a.addr = (k % 2 == 0) ? ia : da; a.we = 1'b0; a.chk_data = 1'b0; a.data = '0;
      acc_q.push_back(a);
      e.port = (k % 2 == 1); e.rdata = rsp; e.err = 1'b0;
      exp_q.push_back(e);
    end
    bus.i_req = 1'b1; bus.i_addr = ia;
    bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = da;
    cyc = 0; seen = 0; prev = 0;
    while (seen < rounds && cyc < 10 * rounds) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (bus.i_done || bus.d_done) begin
        if (seen == 0) check("first_done_edge", cyc, 2);
        else check("done_spacing", cyc - prev, 3);
        prev = cyc;
        seen++;
      end
    end
    check("contention_dones", seen, rounds);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    acc_t a;
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    acc_t a;
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clock);

    run_contention(32'h0000_0040, 32'h0000_0080, 32'h1111_2222, 4);
    run_txn(1'b0, 1'b0, 32'h0000_0100, '0, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4);
    run_txn(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3);
    run_txn(1'b1, 1'b0, 32'h0000_3000, '0, 0, 32'h0, 1'b1, 32'h0, 16);
    run_txn(1'b1, 1'b0, 32'h0000_3004, '0, 15, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 16);
    run_txn(1'b0, 1'b0, 32'h0000_0200, '0, 1, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 2);

    // write abandoned by reset mid-ACCESS
    mem_lat = 0;
    a.addr = 32'h0000_2400; a.we = 1'b1; a.chk_data = 1'b1; a.data = 32'h7777_8888;
    acc_q.push_back(a);
    bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h0000_2400; bus.d_wdata = 32'h7777_8888;
    repeat (3) @(negedge clock);
    check("pre_reset_visit", 32'(bus.mem_visit), 1);
    check("pre_reset_we", 32'(bus.mem_write_enable), 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async");
    bus.d_req = 1'b0;
    bus.d_write = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_contention(32'h0000_0500, 32'h0000_0600, 32'h3333_4444, 2);

    repeat (2) @(negedge clock);
    check("exp_queue_empty", exp_q.size(), 0);
    check("acc_queue_empty", acc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
